// File: rtl/json_pkg.sv
// ----------------------------------------------------------------------------
// json_pkg
// Shared definitions for the JSON field extractor: ASCII byte constants,
// the parse FSM state type and a helper that sizes the key-index field.
// No ports (package).
// ----------------------------------------------------------------------------
package json_pkg;

    localparam logic [7:0] ASCII_QUOTE = 8'h22;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SKIP   = 2'd1,
        DIGITS = 2'd2
    } state_e;

    // A single key still needs a 1-bit index so the port never collapses.
    function automatic int key_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/json_field_extractor_if.sv
// ----------------------------------------------------------------------------
// json_field_extractor_if
// Bundles the byte-stream input, the per-field result pulse, the per-key
// value/stability state and the RAM write port of the JSON field extractor.
//   master : drives byte_in/byte_valid/clr, observes all results
//   slave  : the extractor itself
// ----------------------------------------------------------------------------
interface json_field_extractor_if
    import json_pkg::*;
#(
    parameter int NUM_KEYS = 2,
    parameter int VAL_W    = 10,
    parameter int ADDR_W   = 8
);
    localparam int KEY_W = key_w(NUM_KEYS);

    logic [7:0]                byte_in;
    logic                      byte_valid;
    logic                      clr;
    logic                      val_valid;
    logic [KEY_W-1:0]          val_key;
    logic [VAL_W-1:0]          val_data;
    logic                      val_err;
    logic [NUM_KEYS*VAL_W-1:0] key_values;
    logic [NUM_KEYS-1:0]       stable_mask;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;

    modport master (
        output byte_in, byte_valid, clr,
        input  val_valid, val_key, val_data, val_err,
        input  key_values, stable_mask, wr_en, wr_addr
    );

    modport slave (
        input  byte_in, byte_valid, clr,
        output val_valid, val_key, val_data, val_err,
        output key_values, stable_mask, wr_en, wr_addr
    );

endinterface

// File: rtl/json_key_matcher.sv
// ----------------------------------------------------------------------------
// json_key_matcher
// Tracks progress through the byte pattern  "<key>":  and pulses hit_o
// (combinationally, on the strobe carrying the colon) when it completes.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         synchronous restart of the match index
//   byte_i        received byte, qualified by byte_valid_i
//   pattern_i     key characters, first character in the MS byte
//   len_i         number of key characters in use
//   hit_o         pattern completed on this byte
// ----------------------------------------------------------------------------
module json_key_matcher
    import json_pkg::*;
#(
    parameter int KEY_MAXLEN = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    input  logic [KEY_MAXLEN*8-1:0] pattern_i,
    input  logic [3:0]              len_i,
    output logic                    hit_o
);

    logic [4:0] idx_q, idx_d;
    logic [4:0] last_idx;
    logic [7:0] exp_byte;

    assign last_idx = 5'(len_i) + 5'd2;

    // Byte expected at the current index: opening quote, key characters,
    // closing quote, then the colon.
    always_comb begin
        exp_byte = ASCII_QUOTE;
        for (int j = 0; j < KEY_MAXLEN; j++) begin
            if (idx_q == 5'(j + 1)) begin
                exp_byte = pattern_i[(KEY_MAXLEN-j)*8-1 -: 8];
            end
        end
        if (idx_q == 5'(len_i) + 5'd1) begin
            exp_byte = ASCII_QUOTE;
        end else if (idx_q == last_idx) begin
            exp_byte = ASCII_COLON;
        end else if (idx_q == 5'd0) begin
            exp_byte = ASCII_QUOTE;
        end
    end

    // A mismatching quote may itself open a new key, so restart at 1.
    always_comb begin
        idx_d = idx_q;
        hit_o = 1'b0;
        if (clr_i) begin
            idx_d = 5'd0;
        end else if (byte_valid_i) begin
            if (byte_i == exp_byte) begin
                if (idx_q == last_idx) begin
                    hit_o = 1'b1;
                    idx_d = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end else begin
                idx_d = (byte_i == ASCII_QUOTE) ? 5'd1 : 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 5'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/json_field_extractor.sv
// ----------------------------------------------------------------------------
// json_field_extractor
// Finds up to NUM_KEYS JSON keys in a UART byte stream, converts the unsigned
// decimal value after each key, flags malformed fields, tracks how many
// consecutive identical good values each key has seen, and strobes a RAM
// write once every key is stable.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         json_field_extractor_if.slave: byte_in/byte_valid/clr in;
//               val_valid/val_key/val_data/val_err, key_values, stable_mask,
//               wr_en/wr_addr out (all registered)
// ----------------------------------------------------------------------------
module json_field_extractor
    import json_pkg::*;
#(
    parameter int                           NUM_KEYS   = 2,
    parameter int                           KEY_MAXLEN = 12,
    parameter logic [NUM_KEYS*KEY_MAXLEN*8-1:0] KEY_STR =
        {"direction", 24'h0, "distance", 32'h0},
    parameter logic [NUM_KEYS*4-1:0]        KEY_LEN    = {4'd9, 4'd8},
    parameter int                           MAX_DIGITS = 3,
    parameter int                           VAL_W      = 10,
    parameter int                           STABLE_N   = 3,
    parameter int                           ADDR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    json_field_extractor_if.slave  bus
);

    localparam int KW  = key_w(NUM_KEYS);
    localparam int NDW = $clog2(MAX_DIGITS + 1);
    localparam int CW  = $clog2(STABLE_N + 1);

    logic [NUM_KEYS-1:0] hit;

    state_e                         state_q, state_d;
    logic [KW-1:0]                  cur_key_q, cur_key_d;
    logic [VAL_W-1:0]               acc_q, acc_d;
    logic [NDW-1:0]                 ndig_q, ndig_d;
    logic                           ovf_q, ovf_d;
    logic                           val_valid_q, val_valid_d;
    logic [KW-1:0]                  val_key_q, val_key_d;
    logic [VAL_W-1:0]               val_data_q, val_data_d;
    logic                           val_err_q, val_err_d;
    logic [NUM_KEYS-1:0][VAL_W-1:0] key_values_q, key_values_d;
    logic [NUM_KEYS-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]            mask_q, mask_d;
    logic                           wr_pend_q, wr_pend_d;
    logic                           wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;

    logic                           is_digit;
    logic [3:0]                     digit_val;
    logic                           hit_any;
    logic [KW-1:0]                  hit_idx;
    logic                           close;
    logic                           field_err;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_match
        json_key_matcher #(
            .KEY_MAXLEN (KEY_MAXLEN)
        ) u_match (
            .clk          (clk),
            .rst_n        (rst_n),
            .clr_i        (bus.clr),
            .byte_i       (bus.byte_in),
            .byte_valid_i (bus.byte_valid),
            .pattern_i    (KEY_STR[k*KEY_MAXLEN*8 +: KEY_MAXLEN*8]),
            .len_i        (KEY_LEN[k*4 +: 4]),
            .hit_o        (hit[k])
        );
    end

    assign is_digit  = (bus.byte_in >= ASCII_ZERO) && (bus.byte_in <= ASCII_NINE);
    assign digit_val = bus.byte_in[3:0];

    // Next-state logic for the parser, accumulator, stability counters and
    // write address. Scanning downward leaves the lowest hitting key selected.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_any = 1'b1;
                hit_idx = KW'(k);
            end
        end

        state_d      = state_q;
        cur_key_d    = cur_key_q;
        acc_d        = acc_q;
        ndig_d       = ndig_q;
        ovf_d        = ovf_q;
        val_valid_d  = 1'b0;
        val_key_d    = val_key_q;
        val_data_d   = val_data_q;
        val_err_d    = val_err_q;
        key_values_d = key_values_q;
        cnt_d        = cnt_q;
        wr_pend_d    = 1'b0;
        wr_en_d      = wr_pend_q;
        wr_addr_d    = wr_pend_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        close        = 1'b0;
        field_err    = ovf_q || (ndig_q == '0);

        if (bus.byte_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (hit_any) begin
                        cur_key_d = hit_idx;
                        acc_d     = '0;
                        ndig_d    = '0;
                        ovf_d     = 1'b0;
                        state_d   = SKIP;
                    end
                end
                SKIP: begin
                    if (bus.byte_in == ASCII_SPACE) begin
                        state_d = SKIP;
                    end else if (is_digit) begin
                        acc_d   = VAL_W'(digit_val);
                        ndig_d  = NDW'(1);
                        state_d = DIGITS;
                    end else begin
                        close = 1'b1;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        // Extra digits are swallowed so the field still ends
                        // at its real terminator.
                        if (ndig_q == NDW'(MAX_DIGITS)) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d  = acc_q * VAL_W'(10) + VAL_W'(digit_val);
                            ndig_d = ndig_q + NDW'(1);
                        end
                    end else begin
                        close = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (close) begin
            state_d     = HUNT;
            val_valid_d = 1'b1;
            val_key_d   = cur_key_q;
            val_data_d  = acc_q;
            val_err_d   = field_err;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (cur_key_q == KW'(k)) begin
                    if (!field_err) begin
                        key_values_d[k] = acc_q;
                        if (acc_q == key_values_q[k]) begin
                            cnt_d[k] = (cnt_q[k] == CW'(STABLE_N)) ? cnt_q[k]
                                                                    : cnt_q[k] + CW'(1);
                        end else begin
                            cnt_d[k] = CW'(1);
                        end
                    end else begin
                        cnt_d[k] = '0;
                    end
                end
            end
        end

        if (bus.clr) begin
            state_d      = HUNT;
            val_valid_d  = 1'b0;
            val_key_d    = val_key_q;
            val_data_d   = val_data_q;
            val_err_d    = val_err_q;
            key_values_d = key_values_q;
            cnt_d        = '0;
            wr_en_d      = 1'b0;
            wr_addr_d    = '0;
        end

        for (int k = 0; k < NUM_KEYS; k++) begin
            mask_d[k] = (cnt_d[k] == CW'(STABLE_N));
        end

        // The write is armed by a good close of the last key that leaves
        // every key stable; it fires on the following cycle.
        if (close && !field_err && !bus.clr &&
            (cur_key_q == KW'(NUM_KEYS - 1)) && (&mask_d)) begin
            wr_pend_d = 1'b1;
        end
    end

    // Single register stage for the FSM and every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cur_key_q    <= '0;
            acc_q        <= '0;
            ndig_q       <= '0;
            ovf_q        <= 1'b0;
            val_valid_q  <= 1'b0;
            val_key_q    <= '0;
            val_data_q   <= '0;
            val_err_q    <= 1'b0;
            key_values_q <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            wr_pend_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_key_q    <= cur_key_d;
            acc_q        <= acc_d;
            ndig_q       <= ndig_d;
            ovf_q        <= ovf_d;
            val_valid_q  <= val_valid_d;
            val_key_q    <= val_key_d;
            val_data_q   <= val_data_d;
            val_err_q    <= val_err_d;
            key_values_q <= key_values_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            wr_pend_q    <= wr_pend_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    assign bus.val_valid   = val_valid_q;
    assign bus.val_key     = val_key_q;
    assign bus.val_data    = val_data_q;
    assign bus.val_err     = val_err_q;
    assign bus.key_values  = key_values_q;
    assign bus.stable_mask = mask_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;

endmodule
